// File: rtl/temp_ctrl_pkg.sv
// Shared types, widths and saturating helpers for the thermostat temperature path.
package temp_ctrl_pkg;

  localparam int TEMP_W = 32;
  localparam int ADC_W  = 16;
  localparam int REF_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    CALC,
    ACCUM,
    UPDATE
  } state_t;

  function automatic logic [TEMP_W-1:0] sat_add(input logic [TEMP_W-1:0] a,
                                                input logic [TEMP_W-1:0] b);
    logic [TEMP_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TEMP_W] ? '1 : s[TEMP_W-1:0];
  endfunction

  function automatic logic [TEMP_W-1:0] sat_sub(input logic [TEMP_W-1:0] a,
                                                input logic [TEMP_W-1:0] b);
    return (a < b) ? '0 : (a - b);
  endfunction

endpackage

// File: rtl/temp_sample_controller_hysteresis.sv
// Registered heater/cooler demand with a hysteresis band around the setpoint.
module temp_hysteresis
  import temp_ctrl_pkg::*;
#(
  parameter int HYST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              strobe,
  input  logic [TEMP_W-1:0] avg,
  input  logic [TEMP_W-1:0] setpoint,
  output logic              heater_on,
  output logic              cooler_on
);

  logic [TEMP_W-1:0] lo;
  logic [TEMP_W-1:0] hi;
  logic              heater_nxt;
  logic              cooler_nxt;

  // Setting thresholds lie strictly outside the clearing point, so both can never be on.
  always_comb begin
    lo         = sat_sub(setpoint, TEMP_W'(HYST));
    hi         = sat_add(setpoint, TEMP_W'(HYST));
    heater_nxt = heater_on;
    cooler_nxt = cooler_on;
    if (avg < lo)
      heater_nxt = 1'b1;
    else if (avg >= setpoint)
      heater_nxt = 1'b0;
    if (avg > hi)
      cooler_nxt = 1'b1;
    else if (avg <= setpoint)
      cooler_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      heater_on <= 1'b0;
      cooler_on <= 1'b0;
    end else if (clr) begin
      heater_on <= 1'b0;
      cooler_on <= 1'b0;
    end else if (strobe) begin
      heater_on <= heater_nxt;
      cooler_on <= cooler_nxt;
    end
  end

endmodule

// File: rtl/temp_sample_controller.sv
// Periodic ADC sampling, calibration latching, 2^AVG_LOG2 averaging and thermostat drive.
module temp_sample_controller
  import temp_ctrl_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int ADC_TIMEOUT   = 255,
  parameter int AVG_LOG2      = 2,
  parameter int HYST          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [TEMP_W-1:0] tc_base_cfg,
  input  logic [REF_W-1:0]  tc_ref_cfg,
  input  logic [TEMP_W-1:0] setpoint,
  output logic              adc_req,
  input  logic              adc_ack,
  input  logic [ADC_W-1:0]  adc_data_in,
  output logic [TEMP_W-1:0] calc_tc_base,
  output logic [REF_W-1:0]  calc_tc_ref,
  output logic [ADC_W-1:0]  calc_adc_data,
  input  logic [TEMP_W-1:0] calc_tempc,
  output logic [TEMP_W-1:0] temp_out,
  output logic              temp_valid,
  output logic              heater_on,
  output logic              cooler_on,
  output logic              adc_timeout_err,
  input  logic              err_clr,
  output state_t            dbg_state
);

  localparam int CNT_MAX = (SAMPLE_PERIOD > ADC_TIMEOUT) ? SAMPLE_PERIOD : ADC_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SUM_W   = TEMP_W + AVG_LOG2;
  localparam int N_W     = AVG_LOG2 + 1;
  localparam logic [N_W-1:0] N_LAST = N_W'((1 << AVG_LOG2) - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_add;
  logic [N_W-1:0]    count;
  logic [TEMP_W-1:0] tempc_q;
  logic [TEMP_W-1:0] avg_nxt;
  logic              wait_done;
  logic              req_expired;
  logic              timeout_ev;
  logic              last_sample;
  logic              publish;

  assign wait_done   = (cyc_cnt == CNT_W'(SAMPLE_PERIOD - 1));
  assign req_expired = (cyc_cnt == CNT_W'(ADC_TIMEOUT - 1));
  assign timeout_ev  = enable && (state == REQ) && !adc_ack && req_expired;
  assign last_sample = (count == N_LAST);
  assign sum_add     = sum + SUM_W'(tempc_q);
  assign avg_nxt     = TEMP_W'(sum_add >> AVG_LOG2);
  // Average and thermostat are committed on the last ACCUM edge so both appear in UPDATE.
  assign publish     = enable && (state == ACCUM) && last_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // adc_req is a level held for the whole of REQ; adc_ack is a one-cycle qualifier
  // of adc_data_in accepted on any REQ cycle, including the first.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WAIT;
        WAIT:    if (wait_done) state_nxt = REQ;
        REQ: begin
          if (adc_ack)          state_nxt = CALC;
          else if (req_expired) state_nxt = WAIT;
        end
        CALC:    state_nxt = ACCUM;
        ACCUM:   state_nxt = last_sample ? UPDATE : WAIT;
        UPDATE:  state_nxt = WAIT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    adc_req    = (state == REQ);
    temp_valid = (state == UPDATE);
    dbg_state  = state;
  end

  // One counter serves both the WAIT period and the REQ timeout; it restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cyc_cnt <= '0;
    else if (state_nxt != state)
      cyc_cnt <= '0;
    else if ((state == WAIT) || (state == REQ))
      cyc_cnt <= cyc_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_tc_base  <= '0;
      calc_tc_ref   <= '0;
      calc_adc_data <= '0;
      tempc_q       <= '0;
      sum           <= '0;
      count         <= '0;
      temp_out      <= '0;
    end else if (!enable) begin
      sum   <= '0;
      count <= '0;
    end else begin
      case (state)
        WAIT: if (wait_done) begin
          calc_tc_base <= tc_base_cfg;
          calc_tc_ref  <= tc_ref_cfg;
        end
        REQ:  if (adc_ack) calc_adc_data <= adc_data_in;
        CALC: tempc_q <= calc_tempc;
        ACCUM: begin
          sum   <= sum_add;
          count <= count + 1'b1;
          if (last_sample) temp_out <= avg_nxt;
        end
        UPDATE: begin
          sum   <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             adc_timeout_err <= 1'b0;
    else if (err_clr)    adc_timeout_err <= 1'b0;
    else if (timeout_ev) adc_timeout_err <= 1'b1;
  end

  temp_hysteresis #(.HYST(HYST)) u_hyst (
    .clk       (clk),
    .rst       (rst),
    .clr       (!enable),
    .strobe    (publish),
    .avg       (avg_nxt),
    .setpoint  (setpoint),
    .heater_on (heater_on),
    .cooler_on (cooler_on)
  );

endmodule

// File: tb/tb_temp_sample_controller.sv
// Directed bench for temp_sample_controller with a stub calculator (tempc = adc_data).
module tb_temp_sample_controller;
  import temp_ctrl_pkg::*;

  localparam int SP = 10;
  localparam int TO = 8;
  localparam int AL = 2;
  localparam int HY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] tc_base_cfg = '0;
  logic [7:0]  tc_ref_cfg = '0;
  logic [31:0] setpoint = 32'd25;
  logic        adc_req;
  logic        adc_ack = 1'b0;
  logic [15:0] adc_data_in = '0;
  logic [31:0] calc_tc_base;
  logic [7:0]  calc_tc_ref;
  logic [15:0] calc_adc_data;
  logic [31:0] calc_tempc;
  logic [31:0] temp_out;
  logic        temp_valid;
  logic        heater_on;
  logic        cooler_on;
  logic        adc_timeout_err;
  logic        err_clr = 1'b0;
  state_t      dbg_state;

  assign calc_tempc = {16'b0, calc_adc_data};

  temp_sample_controller #(
    .SAMPLE_PERIOD (SP),
    .ADC_TIMEOUT   (TO),
    .AVG_LOG2      (AL),
    .HYST          (HY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .tc_base_cfg     (tc_base_cfg),
    .tc_ref_cfg      (tc_ref_cfg),
    .setpoint        (setpoint),
    .adc_req         (adc_req),
    .adc_ack         (adc_ack),
    .adc_data_in     (adc_data_in),
    .calc_tc_base    (calc_tc_base),
    .calc_tc_ref     (calc_tc_ref),
    .calc_adc_data   (calc_adc_data),
    .calc_tempc      (calc_tempc),
    .temp_out        (temp_out),
    .temp_valid      (temp_valid),
    .heater_on       (heater_on),
    .cooler_on       (cooler_on),
    .adc_timeout_err (adc_timeout_err),
    .err_clr         (err_clr),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test after 200000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int sample_idx = 0;
  logic [33:0] exp_q[$];   // {temp_out, heater_on, cooler_on}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst) begin
      check("heat_cool_exclusive", {63'b0, heater_on & cooler_on}, 64'd0);
      if (temp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_temp_valid: got temp_out 0x%0h, expected no update", temp_out);
        end else begin
          e = exp_q.pop_front();
          check("temp_out", temp_out, e[33:2]);
          check("heater_on", heater_on, e[1]);
          check("cooler_on", cooler_on, e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_req(output bit ok);
    int n = 0;
    while (adc_req !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = (adc_req === 1'b1);
    check("req_seen", {63'b0, ok}, 64'd1);
  endtask

  task automatic do_sample(input logic [15:0] data, input int dly);
    bit ok;
    logic [31:0] base;
    logic [7:0]  rf;
    base = 32'hCA1B_0000 | 32'(sample_idx);
    rf   = 8'(sample_idx * 3 + 1);
    sample_idx++;
    tc_base_cfg = base;
    tc_ref_cfg  = rf;
    wait_req(ok);
    if (!ok) return;
    check("calc_tc_base", calc_tc_base, base);
    check("calc_tc_ref", calc_tc_ref, rf);
    tc_base_cfg = ~base;
    tc_ref_cfg  = ~rf;
    repeat (dly) @(negedge clk);
    adc_data_in = data;
    adc_ack     = 1'b1;
    @(negedge clk);
    adc_ack = 1'b0;
    check("adc_req_drop", adc_req, 0);
    check("calc_adc_data", calc_adc_data, data);
    check("calc_tc_base_held", calc_tc_base, base);
  endtask

  task automatic batch(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                       input logic [15:0] s3, input int dly, input logic [31:0] exp_t,
                       input logic exp_h, input logic exp_c);
    exp_q.push_back({exp_t, exp_h, exp_c});
    do_sample(s0, dly);
    do_sample(s1, dly);
    do_sample(s2, dly);
    do_sample(s3, dly);
    repeat (3) @(negedge clk);
  endtask

  task automatic timeout_sample(input logic hold_clr, input logic exp_err);
    bit ok;
    int n = 0;
    wait_req(ok);
    if (!ok) return;
    err_clr = hold_clr;
    while (adc_req === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("timeout_req_cycles", n, TO);
    check("timeout_err", adc_timeout_err, exp_err);
    check("timeout_state", dbg_state, WAIT);
    err_clr = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_adc_req", adc_req, 0);
    check("rst_temp_valid", temp_valid, 0);
    check("rst_temp_out", temp_out, 0);
    check("rst_heater", heater_on, 0);
    check("rst_cooler", cooler_on, 0);
    check("rst_err", adc_timeout_err, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // First request: one cycle leaving IDLE plus SP cycles of WAIT.
    tc_base_cfg = 32'hA5A5_0001;
    tc_ref_cfg  = 8'h3C;
    enable = 1'b1;
    n = 0;
    while (adc_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("first_req_latency", n, SP + 1);
    check("first_tc_base", calc_tc_base, 32'hA5A5_0001);
    check("first_tc_ref", calc_tc_ref, 8'h3C);

    // Asynchronous reset in the middle of REQ.
    rst = 1'b1;
    #1;
    check("arst_adc_req", adc_req, 0);
    check("arst_tc_base", calc_tc_base, 0);
    check("arst_tc_ref", calc_tc_ref, 0);
    check("arst_state", dbg_state, IDLE);
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    // Averaging: (20+22+24+26)/4 = 23, inside band around 25.
    setpoint = 32'd25;
    batch(16'd20, 16'd22, 16'd24, 16'd26, 3, 32'd23, 1'b0, 1'b0);

    // Hysteresis around 25 (lo 23, hi 27).
    batch(16'd22, 16'd22, 16'd22, 16'd22, 0, 32'd22, 1'b1, 1'b0);
    batch(16'd24, 16'd24, 16'd24, 16'd24, 1, 32'd24, 1'b1, 1'b0);
    batch(16'd25, 16'd25, 16'd25, 16'd25, 2, 32'd25, 1'b0, 1'b0);
    batch(16'd28, 16'd28, 16'd28, 16'd28, 0, 32'd28, 1'b0, 1'b1);
    batch(16'd26, 16'd26, 16'd26, 16'd26, 1, 32'd26, 1'b0, 1'b1);
    batch(16'd25, 16'd25, 16'd25, 16'd25, 3, 32'd25, 1'b0, 1'b0);

    // Timeouts do not count as samples: (30+30+34+38)/4 = 33.
    exp_q.push_back({32'd33, 1'b0, 1'b1});
    do_sample(16'd30, 1);
    timeout_sample(1'b0, 1'b1);
    do_sample(16'd30, 0);
    timeout_sample(1'b1, 1'b0);
    do_sample(16'd34, 2);
    do_sample(16'd38, 1);
    repeat (3) @(negedge clk);
    check("err_after_clr", adc_timeout_err, 0);

    // Low saturation: setpoint 1 gives lo 0, heater must stay off at avg 0.
    setpoint = 32'd1;
    batch(16'd0, 16'd0, 16'd0, 16'd0, 0, 32'd0, 1'b0, 1'b0);
    // High saturation and truncation: 0x3FFFB >> 2 = 0xFFFE; hi clamps to all ones.
    setpoint = 32'hFFFF_FFFF;
    batch(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1, 32'h0000_FFFE, 1'b1, 1'b0);

    // Stop mid-operation with two samples accumulated.
    setpoint = 32'd25;
    do_sample(16'd10, 0);
    do_sample(16'd10, 0);
    begin
      bit ok;
      wait_req(ok);
    end
    enable = 1'b0;
    @(negedge clk);
    check("stop_state", dbg_state, IDLE);
    check("stop_adc_req", adc_req, 0);
    check("stop_heater", heater_on, 0);
    check("stop_cooler", cooler_on, 0);
    check("stop_temp_out", temp_out, 32'h0000_FFFE);
    adc_data_in = 16'h0077;
    adc_ack = 1'b1;
    @(negedge clk);
    adc_ack = 1'b0;
    check("late_ack_ignored", calc_adc_data, 16'd10);
    check("late_ack_state", dbg_state, IDLE);
    enable = 1'b1;
    // Fresh accumulation: (40+40+40+44)/4 = 41.
    batch(16'd40, 16'd40, 16'd40, 16'd44, 2, 32'd41, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
